// File: rtl/axi_lite_pkg.sv
// Shared response codes and address decode helper for the AXI4-Lite register slave.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int DECODE_ADDR_W = 64;

   // Word address below numRegs means the index fits and every upper bit is zero.
   function automatic logic addrMapped(input logic [DECODE_ADDR_W-1:0] addr,
                                       input int                        numRegs);
      logic [DECODE_ADDR_W-1:0] wordAddr;
      wordAddr = addr >> 2;
      return (wordAddr < DECODE_ADDR_W'(numRegs));
   endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Register array with one byte-enabled write port and one combinational read port.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int IDX_W      = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_wrEn,
   input  logic [IDX_W-1:0]        i_wrIdx,
   input  logic [DATA_WIDTH-1:0]   i_wrData,
   input  logic [DATA_WIDTH/8-1:0] i_wrBe,
   input  logic [IDX_W-1:0]        i_rdIdx,
   output logic [DATA_WIDTH-1:0]   o_rdData
);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_wrEn) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (i_wrBe[b]) begin
               r_regs[i_wrIdx][8*b +: 8] <= i_wrData[8*b +: 8];
            end
         end
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write is not visible yet.
   assign o_rdData = r_regs[i_rdIdx];

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite control/status register slave; independent write (AW/W/B) and read (AR/R) channels.
// Define AXI_LITE_WSTRB_EN to add the WSTRB port and per-byte write enables.
module axi_lite_slave
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
`ifdef AXI_LITE_WSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
`endif
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RVALID,
   input  logic                    RREADY
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic                    r_awHeld;
   logic                    r_wHeld;
   logic [ADDR_WIDTH-1:0]   r_awAddr;
   logic [DATA_WIDTH-1:0]   r_wData;
   logic [DATA_WIDTH/8-1:0] r_wStrb;
   logic                    r_bValid;
   logic [1:0]              r_bResp;
   logic                    r_rValid;
   logic [DATA_WIDTH-1:0]   r_rData;
   logic [1:0]              r_rResp;

   logic                    w_awHs;
   logic                    w_wHs;
   logic                    w_arHs;
   logic                    w_commit;
   logic [ADDR_WIDTH-1:0]   w_wrAddr;
   logic [DATA_WIDTH-1:0]   w_wrData;
   logic [DATA_WIDTH/8-1:0] w_wrStrb;
   logic                    w_wrMapped;
   logic                    w_rdMapped;
   logic [DATA_WIDTH-1:0]   w_rdData;

   assign AWREADY = !r_awHeld && !r_bValid;
   assign WREADY  = !r_wHeld && !r_bValid;
   assign ARREADY = !r_rValid;
   assign BVALID  = r_bValid;
   assign BRESP   = r_bResp;
   assign RVALID  = r_rValid;
   assign RDATA   = r_rData;
   assign RRESP   = r_rResp;

   assign w_awHs   = AWVALID && AWREADY;
   assign w_wHs    = WVALID && WREADY;
   assign w_arHs   = ARVALID && ARREADY;
   assign w_commit = (r_awHeld || w_awHs) && (r_wHeld || w_wHs);

   // A held beat wins over the bus, since the bus value may already have moved on.
   assign w_wrAddr = r_awHeld ? r_awAddr : AWADDR;
   assign w_wrData = r_wHeld ? r_wData : WDATA;
`ifdef AXI_LITE_WSTRB_EN
   assign w_wrStrb = r_wHeld ? r_wStrb : WSTRB;
`else
   assign w_wrStrb = '1;
`endif

   assign w_wrMapped = addrMapped(DECODE_ADDR_W'(w_wrAddr), NUM_REGS);
   assign w_rdMapped = addrMapped(DECODE_ADDR_W'(ARADDR), NUM_REGS);

   axi_lite_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) uRegfile (
      .i_clk    (ACLK),
      .i_reset  (ARESET),
      .i_wrEn   (w_commit && w_wrMapped),
      .i_wrIdx  (w_wrAddr[IDX_W+1:2]),
      .i_wrData (w_wrData),
      .i_wrBe   (w_wrStrb),
      .i_rdIdx  (ARADDR[IDX_W+1:2]),
      .o_rdData (w_rdData)
   );

   // Commit can only happen while BVALID is low, so it never races the B handshake.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_awHeld <= 1'b0;
         r_wHeld  <= 1'b0;
         r_awAddr <= '0;
         r_wData  <= '0;
         r_wStrb  <= '0;
         r_bValid <= 1'b0;
         r_bResp  <= RESP_OKAY;
      end else begin
         if (w_awHs) begin
            r_awAddr <= AWADDR;
         end
         if (w_wHs) begin
            r_wData <= WDATA;
            r_wStrb <= w_wrStrb;
         end
         if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_bValid <= 1'b1;
            r_bResp  <= w_wrMapped ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (w_awHs) begin
               r_awHeld <= 1'b1;
            end
            if (w_wHs) begin
               r_wHeld <= 1'b1;
            end
            if (r_bValid && BREADY) begin
               r_bValid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rValid <= 1'b0;
         r_rData  <= '0;
         r_rResp  <= RESP_OKAY;
      end else if (w_arHs) begin
         r_rValid <= 1'b1;
         r_rData  <= w_rdMapped ? w_rdData : '0;
         r_rResp  <= w_rdMapped ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rValid && RREADY) begin
         r_rValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed self-checking bench for axi_lite_slave; covers byte strobes when AXI_LITE_WSTRB_EN is defined.
module tb_axi_lite_slave;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   int checkCount = 0;
   int errCount   = 0;

   always #5 ACLK = ~ACLK;

   axi_lite_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_REGS   (16)
   ) dut (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .AWADDR  (AWADDR),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .WDATA   (WDATA),
`ifdef AXI_LITE_WSTRB_EN
      .WSTRB   (WSTRB),
`endif
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .BRESP   (BRESP),
      .BVALID  (BVALID),
      .BREADY  (BREADY),
      .ARADDR  (ARADDR),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .RDATA   (RDATA),
      .RRESP   (RRESP),
      .RVALID  (RVALID),
      .RREADY  (RREADY)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic applyStimulus(input logic awValid, input logic [31:0] awAddr,
                                input logic wValid, input logic [31:0] wData);
      AWVALID = awValid;
      AWADDR  = awAddr;
      WVALID  = wValid;
      WDATA   = wData;
   endtask

   // Full write with AW and W together, then one-cycle B acceptance.
   task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] expResp);
      applyStimulus(1'b1, addr, 1'b1, data);
      checkOutput({tag, " awready"}, 32'(AWREADY), 32'd1);
      checkOutput({tag, " wready"}, 32'(WREADY), 32'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput({tag, " bvalid"}, 32'(BVALID), 32'd1);
      checkOutput({tag, " bresp"}, 32'(BRESP), 32'(expResp));
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      checkOutput({tag, " bvalid clr"}, 32'(BVALID), 32'd0);
   endtask

   task automatic doRead(input string tag, input logic [31:0] addr, input logic [31:0] expData,
                         input logic [1:0] expResp);
      ARVALID = 1'b1;
      ARADDR  = addr;
      RREADY  = 1'b1;
      checkOutput({tag, " arready"}, 32'(ARREADY), 32'd1);
      tick();
      ARVALID = 1'b0;
      checkOutput({tag, " rvalid"}, 32'(RVALID), 32'd1);
      checkOutput({tag, " rdata"}, RDATA, expData);
      checkOutput({tag, " rresp"}, 32'(RRESP), 32'(expResp));
      tick();
      RREADY = 1'b0;
      checkOutput({tag, " rvalid clr"}, 32'(RVALID), 32'd0);
   endtask

   task automatic doReset();
      ARESET = 1'b1;
      tick();
      tick();
      ARESET = 1'b0;
   endtask

   initial begin
      ARESET  = 1'b1;
      WSTRB   = 4'hF;
      BREADY  = 1'b0;
      ARVALID = 1'b0;
      ARADDR  = 32'h0;
      RREADY  = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      doReset();

      checkOutput("reset bvalid", 32'(BVALID), 32'd0);
      checkOutput("reset rvalid", 32'(RVALID), 32'd0);
      checkOutput("reset bresp", 32'(BRESP), 32'd0);
      checkOutput("reset rresp", 32'(RRESP), 32'd0);
      checkOutput("reset rdata", RDATA, 32'h0);
      checkOutput("reset awready", 32'(AWREADY), 32'd1);
      checkOutput("reset wready", 32'(WREADY), 32'd1);
      checkOutput("reset arready", 32'(ARREADY), 32'd1);

      // Write reg0 with BREADY held low for five cycles.
      applyStimulus(1'b1, 32'h0, 1'b1, 32'hAABBCCDD);
      checkOutput("wr0 awready", 32'(AWREADY), 32'd1);
      checkOutput("wr0 wready", 32'(WREADY), 32'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bhold bvalid", 32'(BVALID), 32'd1);
         checkOutput("bhold bresp", 32'(BRESP), 32'd0);
         checkOutput("bhold awready", 32'(AWREADY), 32'd0);
         checkOutput("bhold wready", 32'(WREADY), 32'd0);
         tick();
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      checkOutput("bhold bvalid clr", 32'(BVALID), 32'd0);
      doRead("rd0", 32'h0, 32'hAABBCCDD, 2'b00);

      // AW three cycles ahead of W.
      applyStimulus(1'b1, 32'h8, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("awfirst awready", 32'(AWREADY), 32'd0);
         checkOutput("awfirst wready", 32'(WREADY), 32'd1);
         checkOutput("awfirst bvalid", 32'(BVALID), 32'd0);
         if (i < 2) tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h12345678);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("awfirst bvalid", 32'(BVALID), 32'd1);
      checkOutput("awfirst bresp", 32'(BRESP), 32'd0);
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      doRead("rd8", 32'h8, 32'h12345678, 2'b00);
      doRead("rd8 lowbits", 32'hB, 32'h12345678, 2'b00);

      // W three cycles ahead of AW.
      applyStimulus(1'b0, 32'h0, 1'b1, 32'hCAFEF00D);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("wfirst wready", 32'(WREADY), 32'd0);
         checkOutput("wfirst awready", 32'(AWREADY), 32'd1);
         checkOutput("wfirst bvalid", 32'(BVALID), 32'd0);
         if (i < 2) tick();
      end
      applyStimulus(1'b1, 32'hC, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("wfirst bvalid", 32'(BVALID), 32'd1);
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      doRead("rdC", 32'hC, 32'hCAFEF00D, 2'b00);

      // Unmapped addresses, plus the last mapped register.
      doWrite("wr40", 32'h40, 32'hDEADBEEF, 2'b10);
      doRead("rd0 after wr40", 32'h0, 32'hAABBCCDD, 2'b00);
      doRead("rd40", 32'h40, 32'h0, 2'b10);
      doRead("rd hi", 32'h80000000, 32'h0, 2'b10);
      doWrite("wr3C", 32'h3C, 32'h0F0F0F0F, 2'b00);
      doRead("rd3C", 32'h3C, 32'h0F0F0F0F, 2'b00);

      // R held with RREADY low.
      ARVALID = 1'b1;
      ARADDR  = 32'h8;
      RREADY  = 1'b0;
      tick();
      ARVALID = 1'b0;
      ARADDR  = 32'hC;
      for (int i = 0; i < 4; i++) begin
         checkOutput("rhold rvalid", 32'(RVALID), 32'd1);
         checkOutput("rhold rdata", RDATA, 32'h12345678);
         checkOutput("rhold arready", 32'(ARREADY), 32'd0);
         tick();
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      checkOutput("rhold rvalid clr", 32'(RVALID), 32'd0);

      // Same-cycle read and write of reg0: read returns the old value.
      applyStimulus(1'b1, 32'h0, 1'b1, 32'h11111111);
      ARVALID = 1'b1;
      ARADDR  = 32'h0;
      RREADY  = 1'b1;
      BREADY  = 1'b1;
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      ARVALID = 1'b0;
      checkOutput("rw rvalid", 32'(RVALID), 32'd1);
      checkOutput("rw rdata old", RDATA, 32'hAABBCCDD);
      checkOutput("rw bvalid", 32'(BVALID), 32'd1);
      tick();
      BREADY = 1'b0;
      RREADY = 1'b0;
      checkOutput("rw bvalid clr", 32'(BVALID), 32'd0);
      doRead("rw rd0 new", 32'h0, 32'h11111111, 2'b00);

`ifdef AXI_LITE_WSTRB_EN
      doWrite("strb full", 32'h10, 32'hFFFFFFFF, 2'b00);
      WSTRB = 4'b0101;
      doWrite("strb part", 32'h10, 32'h00000000, 2'b00);
      WSTRB = 4'hF;
      doRead("strb rd", 32'h10, 32'hFF00FF00, 2'b00);
`endif

      // Reset with AW held aborts the write; a later lone W must not commit.
      applyStimulus(1'b1, 32'h4, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      doReset();
      checkOutput("abort bvalid", 32'(BVALID), 32'd0);
      checkOutput("abort awready", 32'(AWREADY), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h55555555);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      checkOutput("abort no bvalid", 32'(BVALID), 32'd0);
      doReset();
      doRead("abort rd0", 32'h0, 32'h0, 2'b00);
      doRead("abort rd4", 32'h4, 32'h0, 2'b00);
      doRead("abort rd8", 32'h8, 32'h0, 2'b00);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
